// File: rtl/key_flag_generator.sv
// Four-channel push-button front end: 2-FF synchroniser plus debounce FSM per key,
// emitting a single-cycle flag on each debounced press and a debounced level per key.
module key_flag_generator #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw,
  output logic       flag1,
  output logic       flag2,
  output logic       flag3,
  output logic       flag4,
  output logic [3:0] key_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [3:0] key_p;
  logic [3:0] sync1;
  logic [3:0] sync2;

  // Normalise so that 1 always means pressed; reset loads the released value.
  assign key_p = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= key_p;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             flag_q;
    logic             level_q;

    // Debounce FSM; level_q tracks PRESSED/RELEASE_WAIT, flag_q pulses on entry to PRESSED.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= RELEASED;
        cnt     <= '0;
        flag_q  <= 1'b0;
        level_q <= 1'b0;
      end else begin
        flag_q <= 1'b0;
        case (state)
          RELEASED: begin
            if (sync2[i]) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!sync2[i]) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= PRESSED;
              cnt     <= '0;
              flag_q  <= 1'b1;
              level_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!sync2[i]) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (sync2[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= RELEASED;
              cnt     <= '0;
              level_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state   <= RELEASED;
            cnt     <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign flag1     = g_ch[0].flag_q;
  assign flag2     = g_ch[1].flag_q;
  assign flag3     = g_ch[2].flag_q;
  assign flag4     = g_ch[3].flag_q;
  assign key_level = {g_ch[3].level_q, g_ch[2].level_q, g_ch[1].level_q, g_ch[0].level_q};

endmodule

// File: tb/tb_key_flag_generator.sv
// Bench for key_flag_generator: an active-low and an active-high instance checked every
// cycle against a run-length debounce model, plus directed literal expectations.
module tb_key_flag_generator;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_lo = 4'hF;
  logic [3:0] key_hi = 4'h0;

  logic       lo_f1, lo_f2, lo_f3, lo_f4;
  logic       hi_f1, hi_f2, hi_f3, hi_f4;
  logic [3:0] lo_lvl, hi_lvl;

  key_flag_generator #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .KEY_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .key_raw(key_lo),
    .flag1(lo_f1), .flag2(lo_f2), .flag3(lo_f3), .flag4(lo_f4), .key_level(lo_lvl)
  );

  key_flag_generator #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .KEY_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .key_raw(key_hi),
    .flag1(hi_f1), .flag2(hi_f2), .flag3(hi_f3), .flag4(hi_f4), .key_level(hi_lvl)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Channels 0-3 belong to dut_lo, 4-7 to dut_hi.
  bit m_s1[8], m_s2[8], m_lvl[8], m_flag[8];
  int m_run[8];
  int pulses[8];
  int first[8];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: debounced level flips once the synchronised input has disagreed with it
  // for D+1 consecutive edges; a flip to pressed yields a one-cycle flag.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0; m_flag[i] = 1'b0; m_run[i] = 0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        bit p;
        if (i < 4) p = !key_lo[i];
        else       p = key_hi[i-4];
        m_flag[i] = 1'b0;
        if (m_s2[i] != m_lvl[i]) m_run[i]++;
        else                     m_run[i] = 0;
        if (m_run[i] == int'(D) + 1) begin
          m_lvl[i]  = !m_lvl[i];
          m_run[i]  = 0;
          m_flag[i] = m_lvl[i];
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = p;
      end
    end
  end

  // Per-cycle compare against the model, plus pulse bookkeeping for the directed checks.
  always @(negedge clk) begin
    logic [3:0] lo_f, hi_f, e_lo_f, e_hi_f, e_lo_l, e_hi_l;
    lo_f = {lo_f4, lo_f3, lo_f2, lo_f1};
    hi_f = {hi_f4, hi_f3, hi_f2, hi_f1};
    for (int i = 0; i < 4; i++) begin
      e_lo_f[i] = m_flag[i];   e_lo_l[i] = m_lvl[i];
      e_hi_f[i] = m_flag[i+4]; e_hi_l[i] = m_lvl[i+4];
    end
    check("lo_flags", lo_f, e_lo_f);
    check("lo_level", lo_lvl, e_lo_l);
    check("hi_flags", hi_f, e_hi_f);
    check("hi_level", hi_lvl, e_hi_l);
    for (int i = 0; i < 4; i++) begin
      if (lo_f[i] === 1'b1) begin
        if (pulses[i] == 0) first[i] = cyc;
        pulses[i]++;
      end
      if (hi_f[i] === 1'b1) begin
        if (pulses[i+4] == 0) first[i+4] = cyc;
        pulses[i+4]++;
      end
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) begin
      pulses[i] = 0;
      first[i]  = -1;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // New value is first sampled on the following edge.
  task automatic drive_lo(input logic [3:0] v);
    @(posedge clk); #2; key_lo = v;
  endtask

  task automatic drive_hi(input logic [3:0] v);
    @(posedge clk); #2; key_hi = v;
  endtask

  initial begin
    int e0, r0;
    clear_counts();
    wait_cyc(2);
    @(negedge clk);
    check("reset_lo_out", {lo_f4, lo_f3, lo_f2, lo_f1} | lo_lvl, 4'b0000);
    check("reset_hi_out", {hi_f4, hi_f3, hi_f2, hi_f1} | hi_lvl, 4'b0000);
    #2 rst = 1'b1;
    wait_cyc(3);

    // 1. Clean press of key 0
    clear_counts();
    drive_lo(4'b1110); e0 = cyc + 1;
    wait_cyc(19);
    drive_lo(4'b1111);
    check("t1_level_held", lo_lvl, 4'b0001);
    wait_cyc(12);
    check_int("t1_pulses", pulses[0], 1);
    check_int("t1_flag_cycle", first[0], e0 + 6);
    check("t1_level_released", lo_lvl, 4'b0000);

    // 2. Bounce on key 1
    clear_counts();
    drive_lo(4'b1101); wait_cyc(2);
    drive_lo(4'b1111); wait_cyc(1);
    drive_lo(4'b1101); wait_cyc(2);
    drive_lo(4'b1111); wait_cyc(12);
    check_int("t2_pulses", pulses[1], 0);
    check("t2_level", lo_lvl, 4'b0000);

    // 3. Long hold of key 2 with a release glitch
    clear_counts();
    drive_lo(4'b1011); wait_cyc(99);
    drive_lo(4'b1111); wait_cyc(1);
    drive_lo(4'b1011); wait_cyc(1);
    drive_lo(4'b1111);
    wait_cyc(4);
    check("t3_level_after_glitch", lo_lvl, 4'b0100);
    wait_cyc(8);
    check_int("t3_pulses", pulses[2], 1);
    check("t3_level_released", lo_lvl, 4'b0000);

    // 4. Keys 0 and 3 together
    clear_counts();
    drive_lo(4'b0110); e0 = cyc + 1;
    wait_cyc(10);
    check_int("t4_pulses_k0", pulses[0], 1);
    check_int("t4_pulses_k3", pulses[3], 1);
    check_int("t4_cycle_k0", first[0], e0 + 6);
    check_int("t4_cycle_k3", first[3], e0 + 6);
    drive_lo(4'b1111); wait_cyc(10);

    // 5. Reset in the middle of a press count
    clear_counts();
    drive_lo(4'b1110); e0 = cyc + 1;
    wait_cyc(3);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t5_in_reset", {lo_f4, lo_f3, lo_f2, lo_f1} | lo_lvl, 4'b0000);
    wait_cyc(2);
    #2 rst = 1'b1; r0 = e0 + 5;
    wait_cyc(12);
    check_int("t5_pulses", pulses[0], 1);
    check_int("t5_flag_cycle", first[0], r0 + 6);
    drive_lo(4'b1111); wait_cyc(10);

    // 6. Active-high instance, key 1
    clear_counts();
    drive_hi(4'b0010); e0 = cyc + 1;
    wait_cyc(9);
    drive_hi(4'b0000);
    wait_cyc(12);
    check_int("t6_pulses_k1", pulses[5], 1);
    check_int("t6_flag_cycle", first[5], e0 + 6);
    check_int("t6_pulses_other", pulses[4] + pulses[6] + pulses[7], 0);
    check("t6_level", hi_lvl, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
